// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 ISA constants (load funct3 encodings, writeback queue default depth)
package riscv_pkg;
  localparam int LDQ_DEPTH_DEF = 2;
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;
endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: combinational load formatter selecting byte/half from an aligned word and extending it
// funct3_in: load type; offset_in: address bits [1:0]; word_in: raw aligned word; result_out: formatted value
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      offset_in,
  input  logic [XLEN-1:0] word_in,
  output logic [XLEN-1:0] result_out
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = word_in[{offset_in, 3'b000} +: 8];
  // halfword loads ignore offset bit 0
  assign h = offset_in[1] ? word_in[31:16] : word_in[15:0];
  always_comb
    result_out = funct3_in == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
                 funct3_in == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
                 funct3_in == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
                 funct3_in == F3_LHU ? {{(XLEN-16){1'b0}}, h} : word_in;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and queued, formatted load responses onto one register-file write port
// clk_in/rst_in: clock and asynchronous active-low reset
// alu_*: ALU result handshake; ld_*: load response handshake, formatted before queueing
// wr_en_out/rd_addr_out/rd_out: registered register-file write; ldq_count_out: load queue occupancy
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int LDQ_DEPTH = LDQ_DEPTH_DEF,
  parameter int XLEN      = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         alu_valid_in,
  output logic                         alu_ready_out,
  input  logic [4:0]                   alu_rd_addr_in,
  input  logic [XLEN-1:0]              alu_result_in,
  input  logic                         ld_valid_in,
  output logic                         ld_ready_out,
  input  logic [4:0]                   ld_rd_addr_in,
  input  logic [2:0]                   ld_funct3_in,
  input  logic [1:0]                   ld_byte_off_in,
  input  logic [XLEN-1:0]              ld_data_in,
  output logic                         wr_en_out,
  output logic [4:0]                   rd_addr_out,
  output logic [XLEN-1:0]              rd_out,
  output logic [$clog2(LDQ_DEPTH):0]   ldq_count_out
);
  localparam int PW = $clog2(LDQ_DEPTH);
  localparam int CW = PW + 1;
  logic [CW-1:0] count;
  logic [PW-1:0] wptr, rptr;
  logic [4:0] q_rd [LDQ_DEPTH];
  logic [XLEN-1:0] q_data [LDQ_DEPTH];
  logic [XLEN-1:0] ld_fmt;
  logic full, alu_xfer, ld_xfer, pop, sel;
  logic [4:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  load_align #(.XLEN(XLEN)) u_align (
    .funct3_in (ld_funct3_in),
    .offset_in (ld_byte_off_in),
    .word_in   (ld_data_in),
    .result_out(ld_fmt)
  );
  assign full          = count == CW'(LDQ_DEPTH);
  assign alu_ready_out = count < CW'(LDQ_DEPTH);
  assign ld_ready_out  = count < CW'(LDQ_DEPTH);
  assign ldq_count_out = count;
  assign alu_xfer      = alu_valid_in & alu_ready_out;
  assign ld_xfer       = ld_valid_in & ld_ready_out;
  // a full queue always drains first; otherwise the ALU wins and loads fill idle slots
  assign pop      = full | (~alu_xfer & (count != '0));
  assign sel      = pop | alu_xfer;
  assign sel_rd   = pop ? q_rd[rptr] : alu_rd_addr_in;
  assign sel_data = pop ? q_data[rptr] : alu_result_in;
  always_ff @(posedge clk_in)
    if (ld_xfer) begin
      q_rd[wptr]   <= ld_rd_addr_in;
      q_data[wptr] <= ld_fmt;
    end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      wr_en_out   <= 1'b0;
      rd_addr_out <= '0;
      rd_out      <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
    end else begin
      wr_en_out   <= sel & (sel_rd != 5'd0);
      rd_addr_out <= sel_rd;
      rd_out      <= sel_data;
      if (ld_xfer) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(ld_xfer) - CW'(pop);
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter LDQ_DEPTH, default 2, meaning load-result queue entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-003 SHALL have port clk_in  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alu_valid_in  input  1  ALU result present.
REQ-006 SHALL have port alu_ready_out  output  1  ALU result accepted this cycle.
REQ-007 SHALL have port alu_rd_addr_in  input  5  ALU destination register.
REQ-008 SHALL have port alu_result_in  input  XLEN  ALU result.
REQ-009 SHALL have port ld_valid_in  input  1  load response present.
REQ-010 SHALL have port ld_ready_out  output  1  load response accepted this cycle.
REQ-011 SHALL have port ld_rd_addr_in  input  5  load destination register.
REQ-012 SHALL have port ld_funct3_in  input  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101).
REQ-013 SHALL have port ld_byte_off_in  input  2  address bits [1:0].
REQ-014 SHALL have port ld_data_in  input  XLEN  raw aligned memory word.
REQ-015 SHALL have ports wr_en_out / rd_addr_out / rd_out  output  1 / 5 / XLEN  integer register-file write port.
REQ-016 SHALL have port ldq_count_out  output  $clog2(LDQ_DEPTH)+1  queue occupancy.

Function
REQ-017 Handshakes: transfer occurs when valid and ready are both high at a rising edge; ready SHALL depend on registered state only.
REQ-018 ld_ready_out = (count < LDQ_DEPTH); alu_ready_out = (count < LDQ_DEPTH).
REQ-019 Accepted loads SHALL be formatted before queueing: byte/half selected by ld_byte_off_in, sign-extended (LB/LH) or zero-extended (LBU/LHU); LH/LHU use offset bit 1 only; LW and undefined funct3 pass the word unchanged.
REQ-020 Per-cycle write source priority: (1) queue full -> pop queue head; (2) alu transfer -> ALU result; (3) queue non-empty -> pop head; (4) none -> wr_en_out=0.
REQ-021 Outputs SHALL be registered: the selected source appears on wr_en_out/rd_addr_out/rd_out one cycle after selection; ALU latency 1 cycle, load minimum latency 2 cycles (no bypass around queue).
REQ-022 Destination x0 SHALL produce wr_en_out=0 (entry still consumed); rd_addr_out/rd_out don't-care.
REQ-023 Queue SHALL be strict FIFO; simultaneous push and pop in one cycle SHALL leave count unchanged; pointers wrap modulo LDQ_DEPTH.
REQ-024 Push when full SHALL be impossible by REQ-018; pop when empty SHALL not occur.
REQ-025 Ordering between ALU and load writes to the same register is the issuing pipeline's responsibility; this block SHALL NOT reorder within the load stream.

Reset
REQ-026 rst_in low SHALL asynchronously clear wr_en_out, rd_addr_out, rd_out, pointers and count to 0; queued entries discarded, including mid-drain.
REQ-027 During reset both ready outputs SHALL read 1 (count=0); transfers SHALL be ignored until the first edge after deassertion.

Structure
REQ-028 Load funct3 encodings and LDQ_DEPTH default SHALL live in the shared riscv package with the other ISA constants.
REQ-029 Load formatting SHALL be a combinational sub-module load_align (inputs funct3, offset, word; output XLEN result).

Verification
REQ-030 ALU only: alu rd=5, result=0x0000_1234 -> next cycle wr_en_out=1, rd_addr_out=5, rd_out=0x0000_1234.
REQ-031 Load format: LB off=3 data=0x80FF_0000 -> rd_out=0xFFFF_FF80; LHU off=2 same data -> 0x0000_80FF.
REQ-032 Collision: ALU rd=1 and load rd=2 same cycle -> rd 1 written cycle+1, rd 2 written cycle+2.
REQ-033 Full queue: continuous ALU traffic plus 2 loads -> count=2, both readies 0, loads drained in order, ALU resumes with no lost result.
REQ-034 x0: load rd=0 -> queue pops, wr_en_out stays 0.
REQ-035 Reset mid-drain with count=2 -> outputs and count 0 immediately, no further writes after release.
